// File: rtl/synth_pkg.sv
// Shared types and constants for the synth voice path.
//   voice_state_t : one voice as seen by the allocator scan (active, note, volume, age)
//   alloc_state_e : allocator sequencing states
//   MISS_COUNT_W  : width of the unmatched note-off counter
// The VOICE_*_W widths must agree with the allocator's FREQ_RES_BITS,
// VOLUME_BITS and $clog2(NUM_VOICES).
package synth_pkg;

    localparam int MISS_COUNT_W = 16;
    localparam int VOICE_NOTE_W = 8;
    localparam int VOICE_VOL_W  = 8;
    localparam int VOICE_AGE_W  = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } alloc_state_e;

    typedef struct packed {
        logic                    active;
        logic [VOICE_NOTE_W-1:0] note;
        logic [VOICE_VOL_W-1:0]  volume;
        logic [VOICE_AGE_W-1:0]  age;
    } voice_state_t;

endpackage

// File: rtl/voice_age_tracker.sv
// Per-voice age bookkeeping for oldest-voice stealing.
//   mclk, rst  : clock, synchronous active-high reset
//   alloc_en   : a voice is being (re)allocated this cycle
//   alloc_idx  : index of the voice being allocated; its age clears to 0
//   active     : current active flags; only active voices other than the
//                allocated one age, saturating at NUM_VOICES-1
//   ages       : registered per-voice ages
module voice_age_tracker #(
    parameter int NUM_VOICES = 4,
    parameter int AGE_W      = $clog2(NUM_VOICES)
) (
    input  logic                  mclk,
    input  logic                  rst,
    input  logic                  alloc_en,
    input  logic [AGE_W-1:0]      alloc_idx,
    input  logic [NUM_VOICES-1:0] active,
    output logic [AGE_W-1:0]      ages [NUM_VOICES]
);

    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(NUM_VOICES - 1);

    logic [AGE_W-1:0] age_q [NUM_VOICES];
    logic [AGE_W-1:0] age_d [NUM_VOICES];

    always_comb begin
        for (int i = 0; i < NUM_VOICES; i++) begin
            age_d[i] = age_q[i];
            if (alloc_en) begin
                if (alloc_idx == AGE_W'(i)) begin
                    age_d[i] = '0;
                end else if (active[i] && (age_q[i] != AGE_MAX)) begin
                    age_d[i] = age_q[i] + AGE_W'(1);
                end
            end
        end
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            for (int i = 0; i < NUM_VOICES; i++) age_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_VOICES; i++) age_q[i] <= age_d[i];
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_VOICES; i++) ages[i] = age_q[i];
    end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator feeding a bank of enveloped oscillators.
//   mclk, rst     : master clock, synchronous active-high reset
//   ev_valid/ready: note event handshake (ready only while idle)
//   ev_note_on    : 1 = note-on, 0 = note-off (note-on with zero velocity = off)
//   ev_note       : note number, ev_velocity : note-on velocity
//   voice_volume  : per-voice volume, packed {v[N-1], ..., v[0]}; 0 = released
//   voice_freq    : per-voice note number, held after release for the decay tail
//   voice_busy    : per-voice active flag
//   steal_pulse   : one-cycle pulse after a commit that stole the oldest voice
//   miss_count    : saturating count of note-offs that matched no voice
// An accepted event is scanned one voice per cycle, then resolved in a single
// commit cycle, so voice state never changes while a scan is in progress.
module voice_allocator
    import synth_pkg::*;
#(
    parameter int NUM_VOICES    = 4,
    parameter int VOLUME_BITS   = 8,
    parameter int FREQ_RES_BITS = 8
) (
    input  logic                              mclk,
    input  logic                              rst,
    input  logic                              ev_valid,
    output logic                              ev_ready,
    input  logic                              ev_note_on,
    input  logic [FREQ_RES_BITS-1:0]          ev_note,
    input  logic [VOLUME_BITS-1:0]            ev_velocity,
    output logic [NUM_VOICES*VOLUME_BITS-1:0]   voice_volume,
    output logic [NUM_VOICES*FREQ_RES_BITS-1:0] voice_freq,
    output logic [NUM_VOICES-1:0]             voice_busy,
    output logic                              steal_pulse,
    output logic [MISS_COUNT_W-1:0]           miss_count
);

    localparam int IDX_W = $clog2(NUM_VOICES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    alloc_state_e             state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;

    logic                     ev_on_q, ev_on_d;
    logic [FREQ_RES_BITS-1:0] ev_note_q, ev_note_d;
    logic [VOLUME_BITS-1:0]   ev_vel_q, ev_vel_d;

    logic                     match_found_q, match_found_d;
    logic [IDX_W-1:0]         match_idx_q, match_idx_d;
    logic                     free_found_q, free_found_d;
    logic [IDX_W-1:0]         free_idx_q, free_idx_d;
    logic                     oldest_found_q, oldest_found_d;
    logic [IDX_W-1:0]         oldest_idx_q, oldest_idx_d;
    logic [IDX_W-1:0]         oldest_age_q, oldest_age_d;

    logic [NUM_VOICES-1:0]    active_q, active_d;
    logic [FREQ_RES_BITS-1:0] note_q [NUM_VOICES];
    logic [FREQ_RES_BITS-1:0] note_d [NUM_VOICES];
    logic [VOLUME_BITS-1:0]   volume_q [NUM_VOICES];
    logic [VOLUME_BITS-1:0]   volume_d [NUM_VOICES];

    logic                     steal_pulse_q, steal_pulse_d;
    logic [MISS_COUNT_W-1:0]  miss_count_q, miss_count_d;

    logic                     alloc_en;
    logic [IDX_W-1:0]         alloc_idx;
    logic [IDX_W-1:0]         ages [NUM_VOICES];
    voice_state_t             scan_v;

    voice_age_tracker #(
        .NUM_VOICES (NUM_VOICES),
        .AGE_W      (IDX_W)
    ) u_age (
        .mclk      (mclk),
        .rst       (rst),
        .alloc_en  (alloc_en),
        .alloc_idx (alloc_idx),
        .active    (active_q),
        .ages      (ages)
    );

    assign ev_ready = (state_q == IDLE) && !rst;

    // View of the voice currently under the scan pointer.
    always_comb begin
        scan_v.active = active_q[idx_q];
        scan_v.note   = note_q[idx_q];
        scan_v.volume = volume_q[idx_q];
        scan_v.age    = ages[idx_q];
    end

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        ev_on_d        = ev_on_q;
        ev_note_d      = ev_note_q;
        ev_vel_d       = ev_vel_q;
        match_found_d  = match_found_q;
        match_idx_d    = match_idx_q;
        free_found_d   = free_found_q;
        free_idx_d     = free_idx_q;
        oldest_found_d = oldest_found_q;
        oldest_idx_d   = oldest_idx_q;
        oldest_age_d   = oldest_age_q;
        active_d       = active_q;
        note_d         = note_q;
        volume_d       = volume_q;
        steal_pulse_d  = 1'b0;
        miss_count_d   = miss_count_q;
        alloc_en       = 1'b0;
        alloc_idx      = '0;

        case (state_q)
            IDLE: begin
                if (ev_valid) begin
                    // Zero-velocity note-on collapses to note-off here.
                    ev_on_d        = ev_note_on && (ev_velocity != '0);
                    ev_note_d      = ev_note;
                    ev_vel_d       = ev_velocity;
                    idx_d          = '0;
                    match_found_d  = 1'b0;
                    free_found_d   = 1'b0;
                    oldest_found_d = 1'b0;
                    state_d        = SCAN;
                end
            end

            SCAN: begin
                if (scan_v.active && (scan_v.note == ev_note_q) && !match_found_q) begin
                    match_found_d = 1'b1;
                    match_idx_d   = idx_q;
                end
                // A released voice (volume 0) is free whatever its held pitch.
                if (!(scan_v.active && (scan_v.volume != '0)) && !free_found_q) begin
                    free_found_d = 1'b1;
                    free_idx_d   = idx_q;
                end
                // Strict compare keeps the lowest index on equal ages.
                if (scan_v.active && (!oldest_found_q || (scan_v.age > oldest_age_q))) begin
                    oldest_found_d = 1'b1;
                    oldest_idx_d   = idx_q;
                    oldest_age_d   = scan_v.age;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = COMMIT;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end

            COMMIT: begin
                state_d = IDLE;
                if (ev_on_q) begin
                    if (match_found_q) begin
                        volume_d[match_idx_q] = ev_vel_q;
                    end else if (free_found_q || oldest_found_q) begin
                        alloc_en      = 1'b1;
                        alloc_idx     = free_found_q ? free_idx_q : oldest_idx_q;
                        steal_pulse_d = !free_found_q;
                        active_d[alloc_idx] = 1'b1;
                        note_d[alloc_idx]   = ev_note_q;
                        volume_d[alloc_idx] = ev_vel_q;
                    end
                end else begin
                    if (match_found_q) begin
                        active_d[match_idx_q] = 1'b0;
                        volume_d[match_idx_q] = '0;
                    end else if (miss_count_q != '1) begin
                        miss_count_d = miss_count_q + MISS_COUNT_W'(1);
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            ev_on_q        <= 1'b0;
            ev_note_q      <= '0;
            ev_vel_q       <= '0;
            match_found_q  <= 1'b0;
            match_idx_q    <= '0;
            free_found_q   <= 1'b0;
            free_idx_q     <= '0;
            oldest_found_q <= 1'b0;
            oldest_idx_q   <= '0;
            oldest_age_q   <= '0;
            active_q       <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_q[i]   <= '0;
                volume_q[i] <= '0;
            end
            steal_pulse_q  <= 1'b0;
            miss_count_q   <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            ev_on_q        <= ev_on_d;
            ev_note_q      <= ev_note_d;
            ev_vel_q       <= ev_vel_d;
            match_found_q  <= match_found_d;
            match_idx_q    <= match_idx_d;
            free_found_q   <= free_found_d;
            free_idx_q     <= free_idx_d;
            oldest_found_q <= oldest_found_d;
            oldest_idx_q   <= oldest_idx_d;
            oldest_age_q   <= oldest_age_d;
            active_q       <= active_d;
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_q[i]   <= note_d[i];
                volume_q[i] <= volume_d[i];
            end
            steal_pulse_q  <= steal_pulse_d;
            miss_count_q   <= miss_count_d;
        end
    end

    always_comb begin
        for (int v = 0; v < NUM_VOICES; v++) begin
            voice_volume[v*VOLUME_BITS +: VOLUME_BITS]     = volume_q[v];
            voice_freq[v*FREQ_RES_BITS +: FREQ_RES_BITS]   = note_q[v];
        end
    end

    assign voice_busy  = active_q;
    assign steal_pulse = steal_pulse_q;
    assign miss_count  = miss_count_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator with NUM_VOICES=4, 8-bit note/volume.
// voice_freq / voice_volume are packed {v3, v2, v1, v0}.
module tb_voice_allocator;

    logic        mclk = 1'b0;
    logic        rst;
    logic        ev_valid;
    logic        ev_ready;
    logic        ev_note_on;
    logic [7:0]  ev_note;
    logic [7:0]  ev_velocity;
    logic [31:0] voice_volume;
    logic [31:0] voice_freq;
    logic [3:0]  voice_busy;
    logic        steal_pulse;
    logic [15:0] miss_count;

    int n_cmp = 0;
    int n_err = 0;
    int st;

    always #5 mclk = ~mclk;

    voice_allocator #(
        .NUM_VOICES    (4),
        .VOLUME_BITS   (8),
        .FREQ_RES_BITS (8)
    ) dut (
        .mclk         (mclk),
        .rst          (rst),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .ev_note_on   (ev_note_on),
        .ev_note      (ev_note),
        .ev_velocity  (ev_velocity),
        .voice_volume (voice_volume),
        .voice_freq   (voice_freq),
        .voice_busy   (voice_busy),
        .steal_pulse  (steal_pulse),
        .miss_count   (miss_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge mclk);
        #1;
    endtask

    task automatic do_reset;
        rst      = 1'b1;
        ev_valid = 1'b0;
        #1;
        check("ready_during_rst", 32'(ev_ready), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("ready_after_rst", 32'(ev_ready), 32'd1);
    endtask

    // Sends one event and returns with outputs settled (cycle 7 after handshake).
    // Event fields are scrambled during the scan; the DUT must ignore that.
    task automatic send(input logic on, input logic [7:0] note, input logic [7:0] vel,
                        output int steals);
        int t = 0;
        int ready_low = 0;
        steals = 0;
        while (!ev_ready && t < 50) begin
            tick();
            t++;
        end
        if (!ev_ready) check("ready_timeout", 32'(ev_ready), 32'd1);
        ev_valid    = 1'b1;
        ev_note_on  = on;
        ev_note     = note;
        ev_velocity = vel;
        tick();
        ev_valid    = 1'b0;
        ev_note_on  = ~on;
        ev_note     = ~note;
        ev_velocity = ~vel;
        for (int c = 1; c <= 7; c++) begin
            if (c <= 5 && !ev_ready) ready_low++;
            if (c == 6) check("ready_back", 32'(ev_ready), 32'd1);
            if (steal_pulse) steals++;
            if (c < 7) tick();
        end
        check("ready_low_5", 32'(ready_low), 32'd5);
    endtask

    initial begin
        rst         = 1'b1;
        ev_valid    = 1'b0;
        ev_note_on  = 1'b0;
        ev_note     = 8'd0;
        ev_velocity = 8'd0;
        tick();
        do_reset();
        check("rst_vol",   voice_volume, 32'h0);
        check("rst_freq",  voice_freq,   32'h0);
        check("rst_busy",  32'(voice_busy), 32'h0);
        check("rst_steal", 32'(steal_pulse), 32'h0);
        check("rst_miss",  32'(miss_count), 32'h0);

        // First note-on lands in voice 0.
        send(1'b1, 8'd60, 8'd100, st);
        check("first_freq", voice_freq,   32'h0000_003C);
        check("first_vol",  voice_volume, 32'h0000_0064);
        check("first_busy", 32'(voice_busy), 32'h1);
        check("first_steal", 32'(st), 32'd0);

        // Fill, then steal oldest twice (ages 3,2,1,0 then 0,3,2,1).
        send(1'b1, 8'd62, 8'd100, st);
        send(1'b1, 8'd64, 8'd100, st);
        send(1'b1, 8'd67, 8'd100, st);
        check("fill_freq", voice_freq, 32'h4340_3E3C);
        check("fill_busy", 32'(voice_busy), 32'hF);
        check("fill_steal", 32'(st), 32'd0);
        send(1'b1, 8'd72, 8'd90, st);
        check("steal1_freq", voice_freq, 32'h4340_3E48);
        check("steal1_vol",  voice_volume, 32'h6464_645A);
        check("steal1_pulse", 32'(st), 32'd1);
        send(1'b1, 8'd74, 8'd80, st);
        check("steal2_freq", voice_freq, 32'h4340_4A48);
        check("steal2_pulse", 32'(st), 32'd1);
        check("steal2_busy", 32'(voice_busy), 32'hF);

        // Note-off keeps pitch; freed voice is reused.
        do_reset();
        check("rst2_freq", voice_freq, 32'h0);
        check("rst2_busy", 32'(voice_busy), 32'h0);
        send(1'b1, 8'd60, 8'd100, st);
        send(1'b1, 8'd62, 8'd100, st);
        send(1'b1, 8'd64, 8'd100, st);
        send(1'b1, 8'd67, 8'd100, st);
        send(1'b0, 8'd62, 8'd0, st);
        check("off_vol",  voice_volume, 32'h6464_0064);
        check("off_busy", 32'(voice_busy), 32'hD);
        check("off_freq", voice_freq, 32'h4340_3E3C);
        send(1'b1, 8'd65, 8'd90, st);
        check("reuse_freq", voice_freq, 32'h4340_413C);
        check("reuse_vol",  voice_volume, 32'h6464_5A64);
        check("reuse_busy", 32'(voice_busy), 32'hF);
        check("reuse_steal", 32'(st), 32'd0);

        // Duplicate note-on updates volume only; zero velocity releases.
        do_reset();
        send(1'b1, 8'd60, 8'd100, st);
        send(1'b1, 8'd60, 8'd40, st);
        check("dup_busy", 32'(voice_busy), 32'h1);
        check("dup_vol",  voice_volume, 32'h0000_0028);
        send(1'b1, 8'd60, 8'd0, st);
        check("vel0_busy", 32'(voice_busy), 32'h0);
        check("vel0_vol",  voice_volume, 32'h0);
        check("vel0_freq", voice_freq, 32'h0000_003C);

        // Unmatched note-offs.
        send(1'b0, 8'd50, 8'd0, st);
        check("miss1", 32'(miss_count), 32'd1);
        check("miss1_freq", voice_freq, 32'h0000_003C);
        check("miss1_busy", 32'(voice_busy), 32'h0);
        for (int k = 0; k < 3; k++) send(1'b0, 8'd50, 8'd0, st);
        check("miss4", 32'(miss_count), 32'd4);

        // Reset in the third scan cycle aborts the event.
        send(1'b1, 8'd61, 8'd77, st);
        check("pre_abort_freq", voice_freq, 32'h0000_003D);
        ev_valid    = 1'b1;
        ev_note_on  = 1'b1;
        ev_note     = 8'd70;
        ev_velocity = 8'd55;
        tick();
        ev_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("abort_ready", 32'(ev_ready), 32'd1);
        check("abort_vol",   voice_volume, 32'h0);
        check("abort_freq",  voice_freq, 32'h0);
        check("abort_busy",  32'(voice_busy), 32'h0);
        check("abort_miss",  32'(miss_count), 32'h0);
        repeat (8) tick();
        check("abort_late_busy", 32'(voice_busy), 32'h0);
        check("abort_late_steal", 32'(steal_pulse), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
